// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: opcode constants, command entry layout and the
// legal-opcode check shared by the issue stage and its command FIFO.
package alu_issue_stage_pkg;

  localparam logic [3:0] OP_AND       = 4'd0;
  localparam logic [3:0] OP_OR        = 4'd1;
  localparam logic [3:0] OP_XOR       = 4'd2;
  localparam logic [3:0] OP_NOR       = 4'd3;
  localparam logic [3:0] OP_STICKY_CL = 4'd4;
  localparam logic [3:0] OP_ADD       = 4'd5;
  localparam logic [3:0] OP_SUB       = 4'd6;
  localparam logic [3:0] OP_SLT       = 4'd7;
  localparam logic [3:0] OP_SRL       = 4'd8;
  localparam logic [3:0] OP_SLL       = 4'd9;
  localparam logic [3:0] OP_SRA       = 4'd10;

  // One FIFO entry: 4-bit opcode, 32-bit Y, 32-bit X (68 bits total).
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] y;
    logic [31:0] x;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Opcode 4 is never a computing opcode: it is either illegal or, with the
  // sticky-overflow option, a control command that never reaches the FIFO.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_SRA) && (op != OP_STICKY_CL);
  endfunction

endpackage

// File: rtl/alu_issue_stage_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO with wrap-bit pointers. The head
// entry is presented combinationally and reads as zero while empty.
module alu_cmd_fifo
  import alu_issue_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  cmd_t i_wdata,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output cmd_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_INC = (PW+1)'(1);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  cmd_t        r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
    end
  end

  // Storage needs no reset: stale entries are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU commands, drives the FIFO head into the
// combinational ALU and registers its result behind a valid/ready handshake.
// Optional: define ALU_STICKY_OVF_EN to add out_sticky_ovf; opcode 4 then
// becomes a "clear sticky" command that is consumed without a result.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [3:0]       in_op,
  output logic [31:0]      alu_x,
  output logic [31:0]      alu_y,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_z,
  input  logic             alu_equal,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic             out_equal,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_count
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic             out_sticky_ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_fifo_push;
  logic             w_load;
  logic             w_fire;
  logic             w_legal;
  cmd_t             w_head;
  cmd_t             w_wdata;

  logic             r_valid;
  logic [31:0]      r_z;
  logic             r_equal;
  logic             r_overflow;
  logic             r_zero;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;
  assign w_wdata  = '{op: in_op, y: in_y, x: in_x};
`ifdef ALU_STICKY_OVF_EN
  assign w_fifo_push = w_push & (in_op != OP_STICKY_CL);
`else
  assign w_fifo_push = w_push;
`endif

  assign w_load  = ~w_empty & (~r_valid | out_ready);
  assign w_fire  = r_valid & out_ready;
  assign w_legal = op_legal(w_head.op);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_wdata (w_wdata),
    .i_pop   (w_load),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign alu_x = w_head.x;
  assign alu_y = w_head.y;
  assign alu_op = w_head.op;

  // Result register: capture on load (zeroed for illegal ops), clear valid on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_z        <= '0;
      r_equal    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_z        <= w_legal ? alu_z : '0;
      r_equal    <= w_legal & alu_equal;
      r_overflow <= w_legal & alu_overflow;
      r_zero     <= w_legal & alu_zero;
      r_illegal  <= ~w_legal;
    end else if (w_fire) begin
      r_valid    <= 1'b0;
    end
  end

  // Consumed-result counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (w_fire) r_count <= r_count + CNT_INC;
  end

  assign out_valid    = r_valid;
  assign out_z        = r_z;
  assign out_equal    = r_equal;
  assign out_overflow = r_overflow;
  assign out_zero     = r_zero;
  assign out_illegal  = r_illegal;
  assign out_count    = r_count;

`ifdef ALU_STICKY_OVF_EN
  logic r_sticky;

  // Sticky overflow: a clear command in the same cycle as a set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sticky <= 1'b0;
    else if (w_push && in_op == OP_STICKY_CL)
      r_sticky <= 1'b0;
    else if (w_load && w_legal && alu_overflow)
      r_sticky <= 1'b1;
  end

  assign out_sticky_ovf = r_sticky;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: random and directed stimulus against a queue-based
// reference model; the bench also plays the role of the combinational ALU.
module tb_alu_issue_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
`ifdef ALU_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] z;
    logic        eq;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  op;
  } tcmd_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x, in_y;
  logic [3:0]       in_op;
  logic [31:0]      alu_x, alu_y;
  logic [3:0]       alu_op;
  logic [31:0]      alu_z;
  logic             alu_equal, alu_overflow, alu_zero;
  logic             out_valid, out_ready;
  logic [31:0]      out_z;
  logic             out_equal, out_overflow, out_zero, out_illegal;
  logic [CNT_W-1:0] out_count;
  logic             sticky_obs;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  tcmd_t            m_q[$];
  logic             m_ov;
  logic [31:0]      m_z;
  logic             m_eq, m_ovf, m_zero, m_ill, m_sticky;
  logic [CNT_W-1:0] m_cnt;

  alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_op        (in_op),
    .alu_x        (alu_x),
    .alu_y        (alu_y),
    .alu_op       (alu_op),
    .alu_z        (alu_z),
    .alu_equal    (alu_equal),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_equal    (out_equal),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_illegal  (out_illegal),
    .out_count    (out_count)
`ifdef ALU_STICKY_OVF_EN
    ,
    .out_sticky_ovf (sticky_obs)
`endif
  );

`ifndef ALU_STICKY_OVF_EN
  assign sticky_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural ALU; unassigned opcodes deliberately return non-zero junk.
  function automatic res_t alu_f(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    res_t r;
    r.z = x + y;
    case (op)
      4'd0:  r.z = x & y;
      4'd1:  r.z = x | y;
      4'd2:  r.z = x ^ y;
      4'd3:  r.z = ~(x | y);
      4'd5:  r.z = x + y;
      4'd6:  r.z = x - y;
      4'd7:  r.z = {31'd0, $signed(x) < $signed(y)};
      4'd8:  r.z = x >> y[4:0];
      4'd9:  r.z = x << y[4:0];
      4'd10: r.z = $unsigned($signed(x) >>> y[4:0]);
      default: r.z = x + y + 32'd1;
    endcase
    r.eq   = (x == y);
    r.zero = (r.z == 32'd0);
    r.ovf  = 1'b0;
    if (op == 4'd5) r.ovf = (x[31] == y[31]) && (r.z[31] != x[31]);
    if (op == 4'd6) r.ovf = (x[31] != y[31]) && (r.z[31] != x[31]);
    if (!(op inside {[4'd0:4'd3], [4'd5:4'd10]})) begin
      r.eq = 1'b1; r.ovf = 1'b1; r.zero = 1'b1;
    end
    return r;
  endfunction

  always_comb {alu_z, alu_equal, alu_overflow, alu_zero} = alu_f(alu_x, alu_y, alu_op);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ov = 0; m_z = 0; m_eq = 0; m_ovf = 0; m_zero = 0; m_ill = 0;
    m_cnt = 0; m_sticky = 0;
  endtask

  // One clock edge of intended behaviour, from pre-edge state and inputs.
  task automatic model_step(input logic iv, input logic [31:0] x, input logic [31:0] y,
                            input logic [3:0] op, input logic ordy);
    bit    accept, fire, load;
    tcmd_t c;
    res_t  r;
    accept = iv && (m_q.size() < DEPTH);
    fire   = m_ov && ordy;
    load   = (m_q.size() > 0) && (!m_ov || ordy);
    if (fire) m_cnt = m_cnt + 1'b1;
    if (load) begin
      c = m_q.pop_front();
      r = alu_f(c.x, c.y, c.op);
      m_ov = 1;
      if (c.op inside {[4'd0:4'd3], [4'd5:4'd10]}) begin
        m_z = r.z; m_eq = r.eq; m_ovf = r.ovf; m_zero = r.zero; m_ill = 0;
        if (r.ovf) m_sticky = 1;
      end else begin
        m_z = 0; m_eq = 0; m_ovf = 0; m_zero = 0; m_ill = 1;
      end
    end else if (fire) begin
      m_ov = 0;
    end
    if (accept) begin
      if (STICKY && op == 4'd4) m_sticky = 0;
      else begin
        c.x = x; c.y = y; c.op = op;
        m_q.push_back(c);
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready",     in_ready,     m_q.size() < DEPTH);
    chk("out_valid",    out_valid,    m_ov);
    chk("out_z",        out_z,        m_z);
    chk("out_equal",    out_equal,    m_eq);
    chk("out_overflow", out_overflow, m_ovf);
    chk("out_zero",     out_zero,     m_zero);
    chk("out_illegal",  out_illegal,  m_ill);
    chk("out_count",    out_count,    m_cnt);
    if (STICKY) chk("out_sticky_ovf", sticky_obs, m_sticky);
    if (m_q.size() > 0) begin
      chk("alu_x",  alu_x,  m_q[0].x);
      chk("alu_y",  alu_y,  m_q[0].y);
      chk("alu_op", alu_op, m_q[0].op);
    end else begin
      chk("alu_idle", {alu_op, alu_y, alu_x}, 68'd0);
    end
  endtask

  // Called at a negedge: drive, advance model, cross the edge, compare.
  task automatic cyc(input logic iv, input logic [31:0] x, input logic [31:0] y,
                     input logic [3:0] op, input logic ordy);
    in_valid = iv; in_x = x; in_y = y; in_op = op; out_ready = ordy;
    model_step(iv, x, y, op, ordy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [31:0] rx, ry;
  logic [31:0] held_z;

  initial begin
    rst = 1; in_valid = 0; in_x = 0; in_y = 0; in_op = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    compare_all();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_z", out_z, 32'd0);

    // ADD overflow: result visible one edge after accept
    cyc(1, 32'h7FFF_FFFF, 32'h0000_0001, 4'd5, 1);
    chk("add_not_yet", out_valid, 1'b0);
    cyc(0, 0, 0, 4'd0, 1);
    chk("add_valid", out_valid, 1'b1);
    chk("add_z", out_z, 32'h8000_0000);
    chk("add_ovf", out_overflow, 1'b1);
    chk("add_zero", out_zero, 1'b0);

    // SUB equal operands
    cyc(1, 32'd5, 32'd5, 4'd6, 1);
    cyc(0, 0, 0, 4'd0, 1);
    chk("sub_z", out_z, 32'd0);
    chk("sub_zero", out_zero, 1'b1);
    chk("sub_eq", out_equal, 1'b1);
    chk("sub_ovf", out_overflow, 1'b0);
    chk("sub_cnt", out_count, 16'd1);
    cyc(0, 0, 0, 4'd0, 1);

    // Back-pressure: 1 in output register + 2 queued, 4th refused
    cyc(1, 32'd10, 32'd1, 4'd5, 0);
    cyc(1, 32'd20, 32'd2, 4'd5, 0);
    held_z = out_z;
    chk("bp_first", held_z, 32'd11);
    cyc(1, 32'd30, 32'd3, 4'd5, 0);
    chk("bp_full", in_ready, 1'b0);
    cyc(1, 32'd40, 32'd4, 4'd5, 0);
    chk("bp_hold", out_z, held_z);
    cyc(0, 0, 0, 4'd0, 1);
    chk("bp_drain2", out_z, 32'd22);
    cyc(0, 0, 0, 4'd0, 1);
    chk("bp_drain3", out_z, 32'd33);
    cyc(0, 0, 0, 4'd0, 1);
    chk("bp_empty", out_valid, 1'b0);
    chk("bp_keep_z", out_z, 32'd33);

    // Illegal opcode zeroes the result
    cyc(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd12, 1);
    cyc(0, 0, 0, 4'd0, 1);
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_z", out_z, 32'd0);
    chk("ill_flags", {out_equal, out_overflow, out_zero}, 3'b000);
    cyc(0, 0, 0, 4'd0, 1);

`ifdef ALU_STICKY_OVF_EN
    cyc(1, 32'h7FFF_FFFF, 32'd1, 4'd5, 1);
    cyc(1, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd0, 1);
    chk("sticky_set", sticky_obs, 1'b1);
    cyc(0, 0, 0, 4'd0, 1);
    chk("sticky_hold", sticky_obs, 1'b1);
    cyc(1, 0, 0, 4'd4, 1);
    chk("sticky_clr", sticky_obs, 1'b0);
    cyc(0, 0, 0, 4'd0, 1);
`endif

    // Asynchronous reset with a held result and a full FIFO
    cyc(1, 32'd1, 32'd2, 4'd1, 0);
    cyc(1, 32'd3, 32'd4, 4'd2, 0);
    cyc(1, 32'd5, 32'd6, 4'd3, 0);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_count", out_count, 16'd0);
    chk("arst_alu", {alu_op, alu_y, alu_x}, 68'd0);
    model_reset();
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    compare_all();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = rx;
        1: rx = 32'h7FFF_FFFF;
        2: ry = 32'h8000_0000;
        default: ;
      endcase
      cyc(($urandom_range(0, 9) < 7), rx, ry, 4'($urandom_range(0, 15)),
          ($urandom_range(0, 9) < 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
